// File: rtl/denise_ham_pkg.sv
// Shared constants and types for the Denise HAM colour engine.
package denise_ham_pkg;

  localparam logic [8:0] COLORBASE = 9'h180;

  typedef enum logic [1:0] {
    LOAD = 2'b00,
    MODB = 2'b01,
    MODR = 2'b10,
    MODG = 2'b11
  } ham_ctrl_e;

  // Channel slot within the packed rgb word (red occupies the MSBs).
  localparam int CH_B = 0;
  localparam int CH_G = 1;
  localparam int CH_R = 2;

  typedef struct packed {
    logic      ham;
    logic      ham8;
    ham_ctrl_e ctrl;
    logic [5:0] val;
    logic      clr;
  } stage1_t;

endpackage

// File: rtl/denise_ham_engine_if.sv
// Register-write bus into the HAM engine: 7MHz write strobe, address, data and palette selects.
interface denise_ham_engine_if;
  logic        clk7_en;
  logic [8:1]  reg_address_in;
  logic [11:0] data_in;
  logic        loct;
  logic [2:0]  bank;

  modport master (
    output clk7_en, reg_address_in, data_in, loct, bank
  );

  modport slave (
    input clk7_en, reg_address_in, data_in, loct, bank
  );
endinterface

// File: rtl/denise_ham_palette.sv
// Colour palette RAM: one write port with per-nibble enables, one registered read port.
module denise_ham_palette #(
  parameter int W  = 12,
  parameter int AW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [W-1:0]    wdata,
  input  logic [W/4-1:0]  nib_we,
  input  logic            re,
  input  logic [AW-1:0]   raddr,
  output logic [W-1:0]    rdata
);

  logic [W-1:0] mem [2**AW];

  // Storage is deliberately not reset; software reloads the palette.
  always_ff @(posedge clk) begin
    for (int n = 0; n < W / 4; n++) begin
      if (we && nib_we[n]) begin
        mem[waddr][n*4 +: 4] <= wdata[n*4 +: 4];
      end
    end
  end

  // Read samples the array before this cycle's write lands, so a colliding read sees old data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/denise_ham_engine.sv
// Denise HAM6/HAM8 colour pipeline: palette write, two-stage pixel decode to registered rgb.
// HAM8 decoding is built only when DENISE_HAM8_EN is defined; otherwise ham8 is ignored.
module denise_ham_engine
  import denise_ham_pkg::*;
#(
  parameter int CW  = 4,
  parameter int PAW = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  denise_ham_engine_if.slave   bus,
  input  logic                 ham_en,
  input  logic                 ham8,
  input  logic                 pix_en,
  input  logic                 line_clr,
  input  logic [7:0]           bpldata,
  output logic [3*CW-1:0]      rgb
);

  localparam int NW = 3 * CW / 4;
  // With 8-bit channels, nibbles 0/2/4 are the low halves of blue/green/red.
  localparam logic [NW-1:0] LO_NIB = (CW == 8) ? NW'(6'b010101) : {NW{1'b1}};

  logic            pal_we;
  logic [PAW-1:0]  pal_waddr;
  logic [PAW-1:0]  pal_raddr;
  logic [3*CW-1:0] pal_wdata;
  logic [3*CW-1:0] pal_rdata;
  logic [NW-1:0]   pal_nib_we;
  logic [7:0]      widx;
  logic [7:0]      ridx;
  logic            ham8_eff;
  logic            line_start;
  stage1_t         s1;
  logic [3*CW-1:0] hold;
  logic [3*CW-1:0] rgb_nxt;
  int              ch;

`ifdef DENISE_HAM8_EN
  assign ham8_eff = ham8 && (CW == 8);
`else
  assign ham8_eff = 1'b0;
`endif

  assign widx       = {bus.bank, bus.reg_address_in[5:1]};
  assign pal_waddr  = widx[PAW-1:0];
  assign pal_we     = bus.clk7_en && (bus.reg_address_in[8:6] == COLORBASE[8:6]) &&
                      ((CW == 8) || !bus.loct);
  assign pal_nib_we = bus.loct ? LO_NIB : {NW{1'b1}};
  // Each 4-bit field is replicated across the channel; nibble enables pick which half lands.
  assign pal_wdata  = {{(CW/4){bus.data_in[11:8]}},
                       {(CW/4){bus.data_in[7:4]}},
                       {(CW/4){bus.data_in[3:0]}}};

  always_comb begin
    ridx = {4'b0000, bpldata[3:0]};
    if (!ham_en) begin
      ridx = bpldata;
    end else if (ham8_eff) begin
      ridx = {2'b00, bpldata[7:2]};
    end
  end

  assign pal_raddr = ridx[PAW-1:0];

  denise_ham_palette #(
    .W  (3 * CW),
    .AW (PAW)
  ) u_palette (
    .clk    (clk),
    .rst    (reset),
    .we     (pal_we),
    .waddr  (pal_waddr),
    .wdata  (pal_wdata),
    .nib_we (pal_nib_we),
    .re     (pix_en),
    .raddr  (pal_raddr),
    .rdata  (pal_rdata)
  );

  // Stage 1: control fields travel alongside the registered palette read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1         <= '0;
      line_start <= 1'b1;
    end else if (pix_en) begin
      s1.ham     <= ham_en;
      s1.ham8    <= ham8_eff;
      s1.ctrl    <= ham_ctrl_e'(ham8_eff ? bpldata[1:0] : bpldata[5:4]);
      s1.val     <= ham8_eff ? bpldata[7:2] : {2'b00, bpldata[3:0]};
      s1.clr     <= line_clr | line_start;
      line_start <= 1'b0;
    end
  end

  // Stage 2: modify ops patch one channel of the held colour.
  always_comb begin
    hold    = s1.clr ? '0 : rgb;
    rgb_nxt = hold;
    case (s1.ctrl)
      MODB:    ch = CH_B;
      MODR:    ch = CH_R;
      default: ch = CH_G;
    endcase
    if (!s1.ham || (s1.ctrl == LOAD)) begin
      rgb_nxt = pal_rdata;
`ifdef DENISE_HAM8_EN
    end else if (s1.ham8) begin
      rgb_nxt[ch*CW +: CW] = CW'({s1.val, hold[ch*CW +: 2]});
`endif
    end else begin
      rgb_nxt[ch*CW +: CW] = {(CW/4){s1.val[3:0]}};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb <= '0;
    end else if (pix_en) begin
      rgb <= rgb_nxt;
    end
  end

  // Bank bits above the palette depth are intentionally dropped.
`ifdef DENISE_HAM8_EN
  logic unused_bits;
  assign unused_bits = ^{widx};
`else
  logic unused_bits;
  assign unused_bits = ^{widx, ham8, s1.ham8, s1.val[5:4]};
`endif

endmodule

// File: doc/denise_ham_engine.md
DENISE_HAM_ENGINE -- requirements
Module: denise_ham_engine

Interface
REQ-001 SHALL have parameter CW, default 4, meaning bits per colour channel (legal values 4 or 8).
REQ-002 SHALL have parameter PAW, default 4, meaning palette address bits (4..8; depth 2**PAW).
REQ-003 SHALL have port clk  input  1  28MHz clock.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port clk7_en  input  1  7MHz register-write enable.
REQ-006 SHALL have port reg_address_in  input  8 [8:1]  register address.
REQ-007 SHALL have port data_in  input  12  bus write data.
REQ-008 SHALL have port loct  input  1  low-nibble palette write select.
REQ-009 SHALL have port bank  input  3  palette bank select.
REQ-010 SHALL have port ham_en  input  1  HAM decode enable; when 0, direct palette lookup.
REQ-011 SHALL have port ham8  input  1  HAM8 mode select.
REQ-012 SHALL have port pix_en  input  1  pixel advance strobe.
REQ-013 SHALL have port line_clr  input  1  line-start hold clear.
REQ-014 SHALL have port bpldata  input  8  bitplane pixel data.
REQ-015 SHALL have port rgb  output  3*CW  registered RGB, red MSB.

Function
REQ-016 Palette write SHALL occur on a clk7_en cycle when reg_address_in[8:6]==3'b110 (0x180-0x1BE); index = {bank, reg_address_in[5:1]} truncated to PAW LSBs.
REQ-017 With CW=8 and loct=0, a write SHALL set each channel high nibble from data_in and copy it into the low nibble; with loct=1, only the low nibbles SHALL change.
REQ-018 With CW=4, writes with loct=1 SHALL be ignored.
REQ-019 Pipeline SHALL advance only on pix_en: stage 1 registers palette read and control/data fields; stage 2 computes and registers rgb; latency is exactly 2 pix_en strobes.
REQ-020 A read and a write to the same entry in one cycle SHALL return the old value.
REQ-021 With ham_en=0, rgb SHALL equal palette[bpldata[PAW-1:0]].
REQ-022 HAM6 (ham_en=1, ham8=0): ctrl=bpldata[5:4]; 00 loads palette[bpldata[3:0]]; 01 modifies blue, 10 red, 11 green, using a 4-bit value bpldata[3:0] placed in the channel MSBs; for CW=8 the low nibble is replicated from it. Unmodified channels are held from the previous rgb.
REQ-023 HAM8 (ham_en=1, ham8=1, CW=8): ctrl=bpldata[1:0]; 00 loads palette[bpldata[7:2]]; 01/10/11 modify blue/red/green upper 6 bits with bpldata[7:2], keeping the channel's lower 2 bits; with CW=4, ham8 SHALL be treated as 0.
REQ-024 line_clr sampled with pix_en SHALL force the hold value used by that pixel to 0 (modify ops apply against black).
REQ-025 Without pix_en, rgb and all pipeline registers SHALL hold.

Reset
REQ-026 On reset, rgb, stage registers and the hold value SHALL be 0; the palette is not cleared.
REQ-027 Reset asserted mid-line SHALL take effect asynchronously; the first pixel after release SHALL be treated as line start.

Configuration
REQ-028 Macro DENISE_HAM8_EN defined: HAM8 decoding per REQ-023 SHALL be present. Undefined: HAM8 logic SHALL be omitted, ham8 ignored, and HAM6 only.

Structure
REQ-029 Package denise_ham_pkg SHALL hold COLORBASE (9'h180), the ctrl encodings (LOAD, MODB, MODR, MODG) and the channel index constants.
REQ-030 Palette storage SHALL be a sub-module denise_ham_palette (one write port, one registered read port, nibble write enables).

Verification
REQ-031 CW=4: write 0x180=0x123; bpldata=0x00 -> rgb=0x123 after two pix_en.
REQ-032 HAM6 CW=4: after the 0x123 pixel, bpldata=0x1F -> 0x12F; 0x25 -> 0x52F; 0x37 -> 0x57F.
REQ-033 CW=8 loct: write 0x180=0xABC with loct=0, then 0x180=0x123 with loct=1 -> palette[0]=0xA1B2C3.
REQ-034 HAM8 (macro on, CW=8): palette[0]=0x000000; bpldata=0xFD -> blue=0xFC; then line_clr+0xFE -> rgb=0xFC0000.
REQ-035 Same-cycle write/read of an entry returns the old value; pix_en low for 5 cycles leaves rgb unchanged.
REQ-036 Reset pulse mid-line -> rgb=0 immediately; the next modify op applies against black.
